dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Two-requester arbiter and access sequencer for the 4 KB word-addressed data memory (1024 x 32, combinational read, write on posedge clk). Port 0 serves the CPU load/store path; port 1 serves the program/data loader and debug access. One access is issued per cycle with round-robin priority on conflict. Byte-enabled stores are handled by merging into the current word in the same cycle, and read data and acknowledges are returned on registered outputs.

## Interface
- No parameters. Memory geometry is fixed: word address bits [11:2], 32-bit data.
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 request; held with its payload until m0_gnt.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_be  in  4  port 0 byte enables; bit i selects bits [8i+7:8i]; ignored on reads.
- m0_addr  in  10  port 0 word address, bits [11:2].
- m0_wdata  in  32  port 0 write data.
- m0_gnt  out  1  port 0 granted this cycle (combinational).
- m0_ack  out  1  one-cycle pulse the cycle after a port 0 grant.
- m0_rdata  out  32  port 0 read data, registered; valid when m0_ack is high.
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata: identical meanings for port 1.
- dm_addr  out  10  memory word address, bits [11:2].
- dm_din  out  32  memory write data (merged word).
- dm_we  out  1  memory write enable.
- dm_dout  in  32  memory combinational read data.

## Operation
- Winner selection each cycle:
  - Only one req high: that port wins.
  - Both high: the port not equal to last_grant wins.
  - Neither high: no grant, dm_we = 0.
- last_grant: 1-bit register, updated to the winner on every grant.
- Grant outputs: mX_gnt = 1 for the winner only; dm_addr = winner addr. With no grant, dm_addr = m0_addr.
- Write grant with be != 0:
  - dm_we = 1.
  - dm_din byte i = be[i] ? wdata byte i : dm_dout byte i.
  - This is a read-merge-write completed within the grant cycle.
- Write grant with be == 0: dm_we = 0, no memory change, still acknowledged.
- Read grant: dm_we = 0, and dm_dout is captured into the winner's rdata register at the posedge.
- Write grant: the winner's rdata holds the pre-write word, i.e. the old contents are returned.
- Non-granted port's rdata holds its previous value.
- Back-to-back transactions: a requester that keeps req high after gnt issues a new transaction using the payload present in the next cycle.
- Same-address conflict: accesses are ordered by grant cycle. A read granted the cycle after a write to the same word returns the written data.
- Reset (rst = 1 at posedge):
  - last_grant <= 1, so port 0 wins the first conflict.
  - m0_ack, m1_ack <= 0.
  - m0_rdata, m1_rdata <= 0.
  - While rst is high: all gnt = 0 and dm_we = 0, so memory contents are never altered by a reset cycle, including reset mid-stream.

## Timing
- Grant latency: 0 cycles (same cycle as req). Memory write takes effect at the end of the grant cycle.
- Ack latency: exactly 1 cycle after grant; ack high for exactly 1 cycle per grant.
- Throughput: 1 access per cycle total. Under continuous contention each port gets every other cycle, and max wait is 1 cycle.
- Reset values: gnt 0, ack 0, rdata 0x00000000, dm_we 0, last_grant 1.
- A grant in the cycle that rst deasserts is permitted. A grant in the cycle rst is high is not.

## Test plan
- Single read: memory word 1 = 100, m0 read addr 1 -> m0_gnt same cycle; m0_ack next cycle with m0_rdata = 100; m1 signals idle.
- Byte store: word 2 = 0x00000001, m1 write addr 2, be = 4'b0010, wdata = 0xAABBCCDD -> word 2 becomes 0x0000CC01; m1_ack next cycle; a subsequent m1 read returns 0x0000CC01.
- Contention: both req continuously after reset, m0 reads addr 0, m1 reads addr 1 -> grants alternate m0, m1, m0, m1; each ack arrives one cycle after its grant with rdata 0 and 100 respectively.
- Ordering: m1 writes 0x12345678 to addr 3 (be = 4'hF); the next cycle m0 reads addr 3 -> m0_rdata = 0x12345678.
- Reset mid-stream: m0 write to addr 4 (be = 4'hF, 0xDEADBEEF) held with rst = 1 -> word 4 stays 0, no gnt, ack 0, rdata 0. After rst drops the write is granted and word 4 becomes 0xDEADBEEF.
- be == 0 write: m0 write addr 1, be = 0 -> word 1 stays 100; m0_ack pulses; m0_rdata = 100.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 1024 x 32 data memory.
// Byte-enabled stores merge into the current word in the grant cycle; acks and read data are registered.
module dm_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [9:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [9:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned ADDR_W = 10;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] new_word,
    input logic [DATA_W-1:0] old_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  logic              last_grant_q, last_grant_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              gnt0, gnt1, any_gnt;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] sel_addr;

  // Winner selection: on conflict the port that did not win last time goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
    any_gnt = gnt0 | gnt1;
  end

  // Selected payload defaults to port 0 so dm_addr follows m0_addr when idle.
  always_comb begin
    sel_we    = m0_we;
    sel_be    = m0_be;
    sel_wdata = m0_wdata;
    sel_addr  = m0_addr;
    if (gnt1) begin
      sel_we    = m1_we;
      sel_be    = m1_be;
      sel_wdata = m1_wdata;
      sel_addr  = m1_addr;
    end
  end

  always_comb begin
    dm_addr = sel_addr;
    dm_we   = any_gnt && sel_we && (sel_be != '0);
    dm_din  = merge_bytes(sel_wdata, dm_dout, sel_be);
  end

  // The winner always captures the pre-write word, so writes return old contents.
  always_comb begin
    last_grant_d = last_grant_q;
    m0_ack_d     = gnt0;
    m1_ack_d     = gnt1;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
      m0_rdata_d   = dm_dout;
    end
    if (gnt1) begin
      last_grant_d = 1'b1;
      m1_rdata_d   = dm_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign m0_gnt   = gnt0;
  assign m1_gnt   = gnt1;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of arbitration and memory contents.
module tb_dm_port_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_we;

  logic        mem_clr;
  logic [31:0] mem [1024];

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [1024];
  int          ref_last;
  logic [31:0] exp_rdata [2];
  logic        exp_ack [2];
  int          last_w;

  dm_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (dm_we) begin
      mem[dm_addr] <= dm_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are already applied; checks combinational outputs, then registered ones.
  task automatic step();
    int          w;
    logic        r [2];
    logic        wr [2];
    logic [3:0]  be [2];
    logic [9:0]  ad [2];
    logic [31:0] wd [2];
    logic [31:0] old_word, new_word;
    logic        exp_we;
    logic [9:0]  exp_addr;
    r[0] = m0_req; wr[0] = m0_we; be[0] = m0_be; ad[0] = m0_addr; wd[0] = m0_wdata;
    r[1] = m1_req; wr[1] = m1_we; be[1] = m1_be; ad[1] = m1_addr; wd[1] = m1_wdata;
    #1;
    w = -1;
    if (!rst) begin
      if (r[0] && r[1]) w = (ref_last == 0) ? 1 : 0;
      else if (r[0])    w = 0;
      else if (r[1])    w = 1;
    end
    exp_we   = 1'b0;
    exp_addr = ad[0];
    old_word = 32'h0;
    new_word = 32'h0;
    if (w >= 0) begin
      exp_addr = ad[w];
      old_word = ref_mem[ad[w]];
      new_word = old_word;
      if (wr[w] && be[w] != 4'h0) begin
        exp_we = 1'b1;
        for (int b = 0; b < 4; b++)
          if (be[w][b]) new_word[8*b +: 8] = wd[w][8*b +: 8];
      end
    end
    chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, w == 0});
    chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, w == 1});
    chk("dm_we", {31'b0, dm_we}, {31'b0, exp_we});
    chk("dm_addr", {22'b0, dm_addr}, {22'b0, exp_addr});
    @(posedge clk);
    #1;
    if (rst) begin
      ref_last = 1;
      exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
      exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
    end else begin
      exp_ack[0] = (w == 0);
      exp_ack[1] = (w == 1);
      if (w >= 0) begin
        exp_rdata[w] = old_word;
        ref_last = w;
        if (exp_we) ref_mem[ad[w]] = new_word;
      end
    end
    chk("m0_ack", {31'b0, m0_ack}, {31'b0, exp_ack[0]});
    chk("m1_ack", {31'b0, m1_ack}, {31'b0, exp_ack[1]});
    chk("m0_rdata", m0_rdata, exp_rdata[0]);
    chk("m1_rdata", m1_rdata, exp_rdata[1]);
    chk("mem_word", mem[exp_addr], ref_mem[exp_addr]);
    last_w = w;
    @(negedge clk);
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_last = 1;
    exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
    exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
    last_w = -1;
    rst = 1'b1;
    mem_clr = 1'b1;
    set_m0(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk);

    // Reset state
    step();
    mem_clr = 1'b0;
    step();
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_ack", {31'b0, m1_ack}, 32'h0);
    rst = 1'b0;

    // Preload word 1 = 100, then single read on port 0
    set_m1(1'b1, 1'b1, 4'hF, 10'd1, 32'd100);
    step();
    set_m1(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    set_m0(1'b1, 1'b0, 4'h0, 10'd1, 32'h0);
    step();
    chk("single_read", m0_rdata, 32'd100);
    set_m0(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    step();

    // Byte store merge
    set_m1(1'b1, 1'b1, 4'hF, 10'd2, 32'h0000_0001);
    step();
    set_m1(1'b1, 1'b1, 4'b0010, 10'd2, 32'hAABB_CCDD);
    step();
    chk("byte_store_mem", mem[2], 32'h0000_CC01);
    set_m1(1'b1, 1'b0, 4'h0, 10'd2, 32'h0);
    step();
    chk("byte_store_read", m1_rdata, 32'h0000_CC01);
    set_m1(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);

    // Contention straight after reset: m0 first, then alternating
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_m0(1'b1, 1'b0, 4'h0, 10'd0, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, 10'd1, 32'h0);
    step();
    chk("contend_first_m0", {31'b0, m0_ack}, 32'd1);
    step();
    chk("contend_second_m1", {31'b0, m1_ack}, 32'd1);
    step();
    step();
    chk("contend_m0_rdata", m0_rdata, 32'd0);
    chk("contend_m1_rdata", m1_rdata, 32'd100);
    set_m0(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);

    // Write then read of the same word on consecutive cycles
    set_m1(1'b1, 1'b1, 4'hF, 10'd3, 32'h1234_5678);
    step();
    set_m1(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    set_m0(1'b1, 1'b0, 4'h0, 10'd3, 32'h0);
    step();
    chk("ordering", m0_rdata, 32'h1234_5678);

    // Reset mid-stream holds off a pending write
    set_m0(1'b1, 1'b1, 4'hF, 10'd4, 32'hDEAD_BEEF);
    rst = 1'b1;
    step();
    step();
    chk("rst_hold_mem", mem[4], 32'h0);
    chk("rst_hold_rdata", m0_rdata, 32'h0);
    rst = 1'b0;
    step();
    chk("rst_release_mem", mem[4], 32'hDEAD_BEEF);

    // Write with no byte enables
    set_m0(1'b1, 1'b1, 4'h0, 10'd1, 32'hFFFF_FFFF);
    step();
    chk("be0_mem", mem[1], 32'd100);
    chk("be0_rdata", m0_rdata, 32'd100);
    chk("be0_ack", {31'b0, m0_ack}, 32'd1);
    set_m0(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    step();

    // Randomized traffic; a requester holds its payload until granted
    last_w = -1;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!m0_req || last_w == 0)
        set_m0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
               10'($urandom_range(0, 15)), $urandom);
      if (!m1_req || last_w == 1)
        set_m1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
               10'($urandom_range(0, 15)), $urandom);
      step();
    end

    for (int a = 0; a < 16; a++) chk("final_mem", mem[a], ref_mem[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
